// File: rtl/light_decoder.sv
// light_decoder
//   Receive-side decoder for 24-bit RGB light words. It recovers the 3-bit
//   colour code {R,G,B} from pure words, where every byte is 00 or FF. It
//   flags words that are not pure. A new colour is accepted only after
//   STABLE_CYCLES consecutive matching valid pure samples.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   light[23:0]   RGB word, [23:16]=R [15:8]=G [7:0]=B
//   light_valid   qualifies light
//   colour[2:0]   locked colour code
//   colour_valid  set on the first lock, cleared only by reset
//   is_white      colour_valid && colour==7
//   change_pulse  one-cycle pulse when the locked colour changes
//   bad_sample    one-cycle pulse for a valid, non-pure sample
//   change_count  number of colour changes, saturating

module light_decoder #(
  parameter int STABLE_CYCLES = 3,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [23:0]      light,
  input  logic             light_valid,
  output logic [2:0]       colour,
  output logic             colour_valid,
  output logic             is_white,
  output logic             change_pulse,
  output logic             bad_sample,
  output logic [CNT_W-1:0] change_count
);

  // The run counter only has to reach STABLE_CYCLES, because locking happens
  // on equality.
  localparam int RUN_W = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
  localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(STABLE_CYCLES);

  typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

  function automatic logic byte_pure(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hFF);
  endfunction

  function automatic logic word_pure(input logic [23:0] w);
    return byte_pure(w[23:16]) && byte_pure(w[15:8]) && byte_pure(w[7:0]);
  endfunction

  function automatic logic [2:0] word_code(input logic [23:0] w);
    return {w[23:16] == 8'hFF, w[15:8] == 8'hFF, w[7:0] == 8'hFF};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic [23:0]      light_p0;
  logic             vld_p0;
  logic             pure_p0;
  logic [2:0]       code_p0;

  state_t           state;
  logic [2:0]       cand;
  logic [RUN_W-1:0] run;

  logic [2:0]       nxt_cand;
  logic [RUN_W-1:0] nxt_run;
  logic             retrack;
  logic             lock_hit;
  logic             new_colour;

  // ---- stage p0: input capture ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p0   <= 1'b0;
      light_p0 <= '0;
    end else begin
      vld_p0   <= light_valid;
      light_p0 <= light;
    end
  end

  // ---- stage p1: decode, glitch filter and lock ----
  assign pure_p0 = word_pure(light_p0);
  assign code_p0 = word_code(light_p0);

  // Candidate and run length after a valid pure sample. When a sample in
  // LOCKED matches the locked colour, the decoder does nothing, so retrack is
  // low.
  always_comb begin
    nxt_cand = cand;
    nxt_run  = run;
    retrack  = 1'b1;
    case (state)
      IDLE: begin
        nxt_cand = code_p0;
        nxt_run  = RUN_ONE;
      end
      TRACK: begin
        if (code_p0 == cand) begin
          nxt_run = run + RUN_ONE;
        end else begin
          nxt_cand = code_p0;
          nxt_run  = RUN_ONE;
        end
      end
      default: begin
        if (code_p0 != colour) begin
          nxt_cand = code_p0;
          nxt_run  = RUN_ONE;
        end else begin
          retrack = 1'b0;
        end
      end
    endcase
    lock_hit   = retrack && (nxt_run == RUN_LOCK);
    new_colour = !colour_valid || (nxt_cand != colour);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cand         <= '0;
      run          <= '0;
      colour       <= '0;
      colour_valid <= 1'b0;
      change_pulse <= 1'b0;
      bad_sample   <= 1'b0;
      change_count <= '0;
    end else begin
      change_pulse <= 1'b0;
      bad_sample   <= 1'b0;
      if (vld_p0) begin
        if (!pure_p0) begin
          bad_sample <= 1'b1;
          state      <= IDLE;
          run        <= '0;
        end else if (retrack) begin
          cand <= nxt_cand;
          run  <= nxt_run;
          if (lock_hit) begin
            state        <= LOCKED;
            colour       <= nxt_cand;
            colour_valid <= 1'b1;
            // Re-locking to the colour already shown is silent.
            if (new_colour) begin
              change_pulse <= 1'b1;
              change_count <= sat_inc(change_count);
            end
          end else begin
            state <= TRACK;
          end
        end
      end
    end
  end

  assign is_white = colour_valid && (colour == 3'b111);

endmodule

// File: tb/tb_light_decoder.sv
module tb_light_decoder;

  logic        clk;
  logic        rst;
  logic [23:0] light;
  logic        light_valid;

  logic [2:0] m_colour;
  logic       m_cvalid, m_white, m_pulse, m_bad;
  logic [7:0] m_count;

  logic [2:0] s_colour;
  logic       s_cvalid, s_white, s_pulse, s_bad;
  logic [1:0] s_count;

  logic [2:0] o_colour;
  logic       o_cvalid, o_white, o_pulse, o_bad;
  logic [7:0] o_count;

  int errors = 0;
  int checks = 0;
  int m_pulses = 0;
  int m_bads = 0;
  logic m_saw4 = 1'b0;

  light_decoder #(.STABLE_CYCLES(3), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .light(light), .light_valid(light_valid),
    .colour(m_colour), .colour_valid(m_cvalid), .is_white(m_white),
    .change_pulse(m_pulse), .bad_sample(m_bad), .change_count(m_count)
  );

  light_decoder #(.STABLE_CYCLES(3), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .light(light), .light_valid(light_valid),
    .colour(s_colour), .colour_valid(s_cvalid), .is_white(s_white),
    .change_pulse(s_pulse), .bad_sample(s_bad), .change_count(s_count)
  );

  light_decoder #(.STABLE_CYCLES(1), .CNT_W(8)) dut_one (
    .clk(clk), .rst(rst), .light(light), .light_valid(light_valid),
    .colour(o_colour), .colour_valid(o_cvalid), .is_white(o_white),
    .change_pulse(o_pulse), .bad_sample(o_bad), .change_count(o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulses are high for the whole cycle after the edge that sets them, so the
  // next rising edge still sees the value from before its own update.
  always @(posedge clk) begin
    if (m_pulse) m_pulses++;
    if (m_bad) m_bads++;
    if (m_cvalid && m_colour == 3'd4) m_saw4 = 1'b1;
  end

  task automatic step(input logic v, input logic [23:0] w);
    light       = w;
    light_valid = v;
    @(posedge clk);
    @(negedge clk);
  endtask

  // While light_valid is low, the bus carries an impure word that must be ignored.
  task automatic idle(input int n);
    repeat (n) step(1'b0, 24'hABCDEF);
  endtask

  task automatic test_reset;
    rst = 1'b0; light = 24'hFFFFFF; light_valid = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (m_colour !== 3'd0) begin errors++; $display("FAIL reset_colour: got %0d want 0", m_colour); end
    checks++; if (m_cvalid !== 1'b0) begin errors++; $display("FAIL reset_cvalid: got %b want 0", m_cvalid); end
    checks++; if (m_white !== 1'b0) begin errors++; $display("FAIL reset_white: got %b want 0", m_white); end
    checks++; if (m_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b want 0", m_pulse); end
    checks++; if (m_bad !== 1'b0) begin errors++; $display("FAIL reset_bad: got %b want 0", m_bad); end
    checks++; if (m_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", m_count); end
    rst = 1'b1;
    repeat (3) step(1'b1, 24'hFFFFFF);
    idle(1);
    checks++; if (m_colour !== 3'd7) begin errors++; $display("FAIL white_colour: got %0d want 7", m_colour); end
    checks++; if (m_cvalid !== 1'b1) begin errors++; $display("FAIL white_cvalid: got %b want 1", m_cvalid); end
    checks++; if (m_white !== 1'b1) begin errors++; $display("FAIL white_flag: got %b want 1", m_white); end
    checks++; if (m_pulse !== 1'b1) begin errors++; $display("FAIL white_pulse: got %b want 1", m_pulse); end
    checks++; if (m_count !== 8'd1) begin errors++; $display("FAIL white_count: got %0d want 1", m_count); end
    idle(1);
    checks++; if (m_pulse !== 1'b0) begin errors++; $display("FAIL white_pulse_end: got %b want 0", m_pulse); end
  endtask

  task automatic test_glitch;
    int p0;
    p0 = m_pulses;
    m_saw4 = 1'b0;
    step(1'b1, 24'hFF0000);
    step(1'b1, 24'hFF0000);
    step(1'b1, 24'h00FF00);
    checks++; if (m_colour !== 3'd7) begin errors++; $display("FAIL glitch_hold: got %0d want 7", m_colour); end
    repeat (3) step(1'b1, 24'h00FF00);
    idle(2);
    checks++; if (m_colour !== 3'd2) begin errors++; $display("FAIL glitch_colour: got %0d want 2", m_colour); end
    checks++; if (m_count !== 8'd2) begin errors++; $display("FAIL glitch_count: got %0d want 2", m_count); end
    checks++; if (m_pulses - p0 !== 1) begin errors++; $display("FAIL glitch_pulses: got %0d want 1", m_pulses - p0); end
    checks++; if (m_saw4 !== 1'b0) begin errors++; $display("FAIL glitch_red_seen: got %b want 0", m_saw4); end
    checks++; if (m_white !== 1'b0) begin errors++; $display("FAIL glitch_white: got %b want 0", m_white); end
  endtask

  task automatic test_impure;
    int p0, b0;
    repeat (3) step(1'b1, 24'h0000FF);
    idle(2);
    checks++; if (m_colour !== 3'd1) begin errors++; $display("FAIL blue_colour: got %0d want 1", m_colour); end
    checks++; if (m_count !== 8'd3) begin errors++; $display("FAIL blue_count: got %0d want 3", m_count); end
    p0 = m_pulses;
    b0 = m_bads;
    step(1'b1, 24'h0000FF);
    step(1'b1, 24'h123456);
    step(1'b1, 24'h0000FF);
    step(1'b1, 24'h0000FF);
    step(1'b1, 24'h0000FF);
    idle(2);
    checks++; if (m_bads - b0 !== 1) begin errors++; $display("FAIL impure_bad: got %0d want 1", m_bads - b0); end
    checks++; if (m_pulses - p0 !== 0) begin errors++; $display("FAIL impure_pulses: got %0d want 0", m_pulses - p0); end
    checks++; if (m_colour !== 3'd1) begin errors++; $display("FAIL impure_colour: got %0d want 1", m_colour); end
    checks++; if (m_cvalid !== 1'b1) begin errors++; $display("FAIL impure_cvalid: got %b want 1", m_cvalid); end
    checks++; if (m_count !== 8'd3) begin errors++; $display("FAIL impure_count: got %0d want 3", m_count); end
  endtask

  task automatic test_gaps;
    step(1'b1, 24'hFF00FF);
    idle(5);
    step(1'b1, 24'hFF00FF);
    idle(1);
    step(1'b1, 24'hFF00FF);
    checks++; if (m_colour !== 3'd1) begin errors++; $display("FAIL gaps_early: got %0d want 1", m_colour); end
    idle(1);
    checks++; if (m_colour !== 3'd5) begin errors++; $display("FAIL gaps_colour: got %0d want 5", m_colour); end
    checks++; if (m_pulse !== 1'b1) begin errors++; $display("FAIL gaps_pulse: got %b want 1", m_pulse); end
    checks++; if (m_count !== 8'd4) begin errors++; $display("FAIL gaps_count: got %0d want 4", m_count); end
    checks++; if (m_bad !== 1'b0) begin errors++; $display("FAIL gaps_bad: got %b want 0", m_bad); end
    idle(1);
    checks++; if (m_pulse !== 1'b0) begin errors++; $display("FAIL gaps_pulse_end: got %b want 0", m_pulse); end
  endtask

  task automatic test_saturation;
    logic [23:0] words [5];
    logic [2:0]  codes [5];
    int          exp_cnt;
    words = '{24'h0000FF, 24'h00FF00, 24'h0000FF, 24'h00FF00, 24'h0000FF};
    codes = '{3'd1, 3'd2, 3'd1, 3'd2, 3'd1};
    // Reset in the middle of a run, away from any clock edge.
    step(1'b1, 24'hFF0000);
    step(1'b1, 24'hFF0000);
    #2 rst = 1'b0;
    #1;
    checks++; if (m_cvalid !== 1'b0) begin errors++; $display("FAIL async_cvalid: got %b want 0", m_cvalid); end
    checks++; if (m_colour !== 3'd0) begin errors++; $display("FAIL async_colour: got %0d want 0", m_colour); end
    checks++; if (m_count !== 8'd0) begin errors++; $display("FAIL async_count: got %0d want 0", m_count); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      repeat (3) step(1'b1, words[k]);
      idle(1);
      exp_cnt = (k + 1 > 3) ? 3 : k + 1;
      checks++; if (s_pulse !== 1'b1) begin errors++; $display("FAIL sat_pulse%0d: got %b want 1", k, s_pulse); end
      checks++; if (s_count !== 2'(exp_cnt)) begin errors++; $display("FAIL sat_count%0d: got %0d want %0d", k, s_count, exp_cnt); end
      checks++; if (s_colour !== codes[k]) begin errors++; $display("FAIL sat_colour%0d: got %0d want %0d", k, s_colour, codes[k]); end
      if (k == 0) begin
        checks++; if (m_count !== 8'd1) begin errors++; $display("FAIL post_reset_count: got %0d want 1", m_count); end
        checks++; if (m_colour !== 3'd1) begin errors++; $display("FAIL post_reset_colour: got %0d want 1", m_colour); end
      end
    end
  endtask

  task automatic test_single;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (o_cvalid !== 1'b0) begin errors++; $display("FAIL one_reset_cvalid: got %b want 0", o_cvalid); end
    rst = 1'b1;
    step(1'b1, 24'h000000);
    idle(1);
    checks++; if (o_colour !== 3'd0) begin errors++; $display("FAIL one_black_colour: got %0d want 0", o_colour); end
    checks++; if (o_cvalid !== 1'b1) begin errors++; $display("FAIL one_black_cvalid: got %b want 1", o_cvalid); end
    checks++; if (o_pulse !== 1'b1) begin errors++; $display("FAIL one_black_pulse: got %b want 1", o_pulse); end
    checks++; if (o_count !== 8'd1) begin errors++; $display("FAIL one_black_count: got %0d want 1", o_count); end
    step(1'b1, 24'h00FFFF);
    idle(1);
    checks++; if (o_colour !== 3'd3) begin errors++; $display("FAIL one_cyan_colour: got %0d want 3", o_colour); end
    checks++; if (o_pulse !== 1'b1) begin errors++; $display("FAIL one_cyan_pulse: got %b want 1", o_pulse); end
    checks++; if (o_count !== 8'd2) begin errors++; $display("FAIL one_cyan_count: got %0d want 2", o_count); end
    checks++; if (o_white !== 1'b0) begin errors++; $display("FAIL one_cyan_white: got %b want 0", o_white); end
  endtask

  initial begin
    rst = 1'b0;
    light = '0;
    light_valid = 1'b0;
    @(negedge clk);
    test_reset;
    test_glitch;
    test_impure;
    test_gaps;
    test_saturation;
    test_single;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
